// File: rtl/seq_scan_ctrl.sv
// Sequencer for a serial pattern detector: debounces start, latches the switch word,
// clears the detector, streams the word MSB first and collects the detector's hits.
module seq_scan_ctrl #(
    parameter int WIDTH    = 8,
    parameter int DEBOUNCE = 4,
    parameter int LAT      = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic [WIDTH-1:0]           switch,
    input  logic                       det_hit,
    output logic                       det_clear,
    output logic                       bit_out,
    output logic                       bit_valid,
    output logic                       busy,
    output logic                       done,
    output logic                       found,
    output logic [$clog2(WIDTH+1)-1:0] hit_count,
    output logic [$clog2(WIDTH)-1:0]   first_pos
);

    localparam int IW  = $clog2(WIDTH);
    localparam int CW  = $clog2(WIDTH + 1);
    localparam int DBW = $clog2(DEBOUNCE + 1);
    localparam int LW  = (LAT > 1) ? $clog2(LAT) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_SCAN,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t          r_state;
    state_t          w_state_next;

    logic [DBW-1:0]  r_db_cnt;
    logic            r_armed;
    logic            w_trigger;
    logic            w_accept;

    logic [WIDTH-1:0] r_word;
    logic [IW-1:0]    r_index;
    logic [LW-1:0]    r_drain_cnt;
    logic [CW-1:0]    r_hit_count;
    logic [IW-1:0]    r_first_pos;
    logic             r_found;

    logic             r_pipe_valid [LAT];
    logic [IW-1:0]    r_pipe_idx   [LAT];
    logic             w_hit_counted;

    // Trigger fires once per press; re-arming needs start to be seen low.
    assign w_trigger = r_armed && start && (r_db_cnt == DBW'(DEBOUNCE - 1));
    assign w_accept  = w_trigger && ((r_state == S_IDLE) || (r_state == S_DONE));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_db_cnt <= '0;
            r_armed  <= 1'b0;
        end else if (!start) begin
            r_db_cnt <= '0;
            r_armed  <= 1'b1;
        end else if (w_trigger) begin
            r_db_cnt <= '0;
            r_armed  <= 1'b0;
        end else if (r_armed) begin
            r_db_cnt <= r_db_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE, S_DONE: if (w_accept) w_state_next = S_CLEAR;
            S_CLEAR:        w_state_next = S_SCAN;
            S_SCAN:         if (r_index == '0) w_state_next = S_DRAIN;
            S_DRAIN:        if (r_drain_cnt == LW'(LAT - 1)) w_state_next = S_DONE;
            default:        w_state_next = S_IDLE;
        endcase
    end

    always_comb begin
        det_clear = 1'b0;
        bit_out   = 1'b0;
        bit_valid = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        case (r_state)
            S_CLEAR: begin
                det_clear = 1'b1;
                busy      = 1'b1;
            end
            S_SCAN: begin
                bit_valid = 1'b1;
                bit_out   = r_word[r_index];
                busy      = 1'b1;
            end
            S_DRAIN: busy = 1'b1;
            S_DONE:  done = 1'b1;
            default: ;
        endcase
    end

    // Each emitted bit's index travels alongside the detector latency so a hit
    // can be attributed to the bit that completed the pattern.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < LAT; k++) begin
                r_pipe_valid[k] <= 1'b0;
                r_pipe_idx[k]   <= '0;
            end
        end else begin
            for (int k = LAT - 1; k > 0; k--) begin
                r_pipe_valid[k] <= r_pipe_valid[k-1];
                r_pipe_idx[k]   <= r_pipe_idx[k-1];
            end
            r_pipe_valid[0] <= (r_state == S_SCAN);
            r_pipe_idx[0]   <= r_index;
        end
    end

    assign w_hit_counted = r_pipe_valid[LAT-1] && det_hit;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_word      <= '0;
            r_index     <= '0;
            r_drain_cnt <= '0;
            r_hit_count <= '0;
            r_first_pos <= '0;
            r_found     <= 1'b0;
        end else begin
            if (w_accept) begin
                r_word      <= switch;
                r_hit_count <= '0;
                r_first_pos <= '0;
                r_found     <= 1'b0;
            end else if (w_hit_counted) begin
                if (r_hit_count != CW'(WIDTH)) r_hit_count <= r_hit_count + 1'b1;
                if (!r_found) begin
                    r_first_pos <= r_pipe_idx[LAT-1];
                    r_found     <= 1'b1;
                end
            end

            if (r_state == S_CLEAR) begin
                r_index <= IW'(WIDTH - 1);
            end else if ((r_state == S_SCAN) && (r_index != '0)) begin
                r_index <= r_index - 1'b1;
            end

            if (r_state == S_SCAN) begin
                r_drain_cnt <= '0;
            end else if (r_state == S_DRAIN) begin
                r_drain_cnt <= r_drain_cnt + 1'b1;
            end
        end
    end

    assign hit_count = r_hit_count;
    assign first_pos = r_first_pos;
    assign found     = r_found;

endmodule

// File: tb/tb_seq_scan_ctrl.sv
// Directed bench for seq_scan_ctrl driving a behavioural 1001 detector with
// one cycle of latency; expected values are hand-computed per scenario.
module tb_seq_scan_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] switch;
    logic       det_hit;
    logic       det_clear;
    logic       bit_out;
    logic       bit_valid;
    logic       busy;
    logic       done;
    logic       found;
    logic [3:0] hit_count;
    logic [2:0] first_pos;

    logic       force_hit;
    logic [3:0] det_hist;
    logic       det_hit_reg;

    int n_tests = 0;
    int n_fail  = 0;

    seq_scan_ctrl #(.WIDTH(8), .DEBOUNCE(4), .LAT(1)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .switch    (switch),
        .det_hit   (det_hit),
        .det_clear (det_clear),
        .bit_out   (bit_out),
        .bit_valid (bit_valid),
        .busy      (busy),
        .done      (done),
        .found     (found),
        .hit_count (hit_count),
        .first_pos (first_pos)
    );

    always #5 clk = ~clk;

    // External 1001 detector: registered hit one cycle after the completing bit.
    always @(posedge clk) begin
        if (det_clear) begin
            det_hist    <= 4'b0000;
            det_hit_reg <= 1'b0;
        end else if (bit_valid) begin
            det_hist    <= {det_hist[2:0], bit_out};
            det_hit_reg <= ({det_hist[2:0], bit_out} == 4'b1001);
        end else begin
            det_hit_reg <= 1'b0;
        end
    end

    assign det_hit = det_hit_reg | force_hit;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_det_clear"}, det_clear, 0);
        check({tag, "_bit_out"},   bit_out,   0);
        check({tag, "_bit_valid"}, bit_valid, 0);
        check({tag, "_busy"},      busy,      0);
        check({tag, "_done"},      done,      0);
        check({tag, "_found"},     found,     0);
        check({tag, "_hit_count"}, hit_count, 0);
        check({tag, "_first_pos"}, first_pos, 0);
    endtask

    // Hold start high; the trigger fires on the 4th high cycle, CLEAR follows.
    task automatic press4(input logic [7:0] word);
        switch = word;
        start  = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("pre_trigger_clear", det_clear, 0);
        end
        tick();
    endtask

    // Entered in the CLEAR cycle; runs through SCAN and DRAIN into DONE.
    task automatic scan_body(input logic [7:0] word, input int exp_cnt, input int exp_pos,
                             input int exp_found, input bit hold, input bit repress);
        check("clear_pulse",     det_clear, 1);
        check("clear_busy",      busy,      1);
        check("clear_valid",     bit_valid, 0);
        check("clear_done",      done,      0);
        check("clear_hit_count", hit_count, 0);
        check("clear_found",     found,     0);
        if (!hold) start = 1'b0;
        switch = ~word;
        for (int i = 7; i >= 0; i--) begin
            tick();
            if (repress && i == 6) start = 1'b1;
            if (repress && i == 1) start = 1'b0;
            check("scan_valid", bit_valid, 1);
            check("scan_bit",   bit_out,   word[i]);
            check("scan_busy",  busy,      1);
            check("scan_clear", det_clear, 0);
        end
        tick();
        check("drain_busy",  busy,      1);
        check("drain_valid", bit_valid, 0);
        check("drain_done",  done,      0);
        tick();
        check("done_level",  done,      1);
        check("done_busy",   busy,      0);
        check("hit_count",   hit_count, exp_cnt);
        check("first_pos",   first_pos, exp_pos);
        check("found",       found,     exp_found);
        $display("[TB] scan word=%08b hits=%0d first=%0d found=%0d", word, hit_count, first_pos, found);
    endtask

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        switch    = 8'h00;
        force_hit = 1'b0;
        tick();
        tick();
        check_all_zero("reset");
        rst = 1'b0;
        tick();

        // Bounce: 3 high, 1 low, 2 high, low -- never reaches the threshold.
        start = 1'b1;
        for (int k = 0; k < 3; k++) begin tick(); check("bounce_a_busy", busy, 0); end
        start = 1'b0;
        tick();
        start = 1'b1;
        for (int k = 0; k < 2; k++) begin tick(); check("bounce_b_busy", busy, 0); end
        start = 1'b0;
        for (int k = 0; k < 3; k++) begin tick(); check("bounce_idle", det_clear | busy | done, 0); end
        $display("[TB] bounce: no trigger");

        // Hit forced while IDLE must be ignored.
        force_hit = 1'b1;
        tick();
        tick();
        force_hit = 1'b0;
        check("idle_force_count", hit_count, 0);
        check("idle_force_found", found,     0);
        $display("[TB] idle forced hit: count=%0d", hit_count);

        press4(8'b1001_0000);
        scan_body(8'b1001_0000, 1, 4, 1, 1'b0, 1'b0);

        // Hit forced while DONE must leave results alone.
        force_hit = 1'b1;
        for (int k = 0; k < 3; k++) tick();
        force_hit = 1'b0;
        check("done_force_count", hit_count, 1);
        check("done_force_pos",   first_pos, 4);
        check("done_force_done",  done,      1);
        $display("[TB] done forced hit: count=%0d", hit_count);

        press4(8'b1001_0010);
        scan_body(8'b1001_0010, 2, 4, 1, 1'b0, 1'b0);

        press4(8'hFF);
        scan_body(8'hFF, 0, 0, 0, 1'b0, 1'b0);

        // Re-press during SCAN is discarded and does not queue.
        press4(8'b0100_1001);
        scan_body(8'b0100_1001, 2, 3, 1, 1'b0, 1'b1);
        for (int k = 0; k < 4; k++) begin tick(); check("repress_no_rescan", det_clear | busy, 0); end
        check("repress_done_held", done, 1);

        // Start held for 20 cycles yields exactly one scan.
        press4(8'b1001_0000);
        scan_body(8'b1001_0000, 1, 4, 1, 1'b1, 1'b0);
        for (int k = 0; k < 6; k++) begin tick(); check("held_no_rescan", det_clear | busy, 0); end
        start = 1'b0;
        tick();
        check("held_release_done", done, 1);
        press4(8'b0000_1001);
        scan_body(8'b0000_1001, 1, 0, 1, 1'b0, 1'b0);

        // Reset in the 4th SCAN cycle, start held high throughout.
        press4(8'b1001_0000);
        check("rst_clear_pulse", det_clear, 1);
        for (int k = 0; k < 4; k++) tick();
        check("rst_in_scan", bit_valid, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_all_zero("mid_reset");
        tick();
        check("post_reset_hit_ignored", hit_count, 0);
        for (int k = 0; k < 6; k++) begin tick(); check("post_reset_no_trigger", det_clear | busy, 0); end
        $display("[TB] mid-scan reset: outputs cleared, no trigger while held");
        start = 1'b0;
        tick();
        press4(8'b1001_0000);
        scan_body(8'b1001_0000, 1, 4, 1, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
